// File: rtl/seq_fsm_pat_det_mo_pkg.sv
// Shared helpers for the serial pattern detector: state width, KMP next-state
// function and overlap mode constants.
package seq_fsm_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // State counts matched bits 0..pat_w, so it needs pat_w+1 codes.
    function automatic int st_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Next state after holding k matched bits and receiving b: the longest
    // prefix of the pattern that ends the string (first k pattern bits, b).
    // Bit pat_w-1 of pattern is the first bit on the wire.
    function automatic int kmp_next(input int pat_w, input logic [15:0] pattern,
                                    input int k, input logic b);
        int          best;
        logic        ok;
        logic [16:0] s;
        best = 0;
        s    = '0;
        for (int i = 0; i < k; i++) s[i] = pattern[pat_w-1-i];
        s[k] = b;
        for (int j = 1; j <= pat_w; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < j; i++)
                    if (pattern[pat_w-1-i] != s[k+1-j+i]) ok = 1'b0;
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_fsm_pat_det_mo_if.sv
// Bus of the pattern detector; sticky `seen` exists only with
// SEQ_FSM_PAT_DET_STICKY_EN defined.
interface seq_fsm_pat_det_mo_if
    import seq_fsm_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    localparam int SW = st_w(PAT_W);

    logic             in_;
    logic             in_val;
    logic             overlap;
    logic             cnt_clr;
    logic [SW-1:0]    state;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
`ifdef SEQ_FSM_PAT_DET_STICKY_EN
    logic             seen;

    modport master (output in_, in_val, overlap, cnt_clr,
                    input  state, out, match_cnt, seen);
    modport slave  (input  in_, in_val, overlap, cnt_clr,
                    output state, out, match_cnt, seen);
`else
    modport master (output in_, in_val, overlap, cnt_clr,
                    input  state, out, match_cnt);
    modport slave  (input  in_, in_val, overlap, cnt_clr,
                    output state, out, match_cnt);
`endif

endinterface

// File: rtl/seq_fsm_pat_det_mo_next.sv
// Combinational next-state logic: (state, in_, overlap) -> state_next, with the
// KMP transition table built at elaboration.
module seq_fsm_pat_next
    import seq_fsm_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               SW      = st_w(PAT_W)
) (
    input  logic [SW-1:0] state,
    input  logic          in_,
    input  logic          overlap,
    output logic [SW-1:0] state_next
);

    logic [PAT_W:0][1:0][SW-1:0] tbl;

    for (genvar k = 0; k <= PAT_W; k++) begin : g_k
        for (genvar b = 0; b < 2; b++) begin : g_b
            localparam logic [SW-1:0] NXT = SW'(kmp_next(PAT_W, 16'(PATTERN), k, 1'(b)));
            assign tbl[k][b] = NXT;
        end
    end

    always_comb begin
        state_next = '0;
        for (int k = 0; k <= PAT_W; k++)
            if (state == SW'(k)) state_next = tbl[k][in_];
        // Non-overlap mode restarts from scratch after a full match.
        if (state == SW'(PAT_W) && overlap == OVL_OFF)
            state_next = (in_ == PATTERN[PAT_W-1]) ? SW'(1) : SW'(0);
    end

endmodule

// File: rtl/seq_fsm_pat_det_mo.sv
// Moore serial pattern detector with input qualifier, overlap mode and a
// saturating match counter. Optional sticky flag: SEQ_FSM_PAT_DET_STICKY_EN.
module seq_fsm_pat_det_mo
    import seq_fsm_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter int               CNT_W   = 8
) (
    input logic                 clk,
    input logic                 reset,
    seq_fsm_pat_det_mo_if.slave bus
);

    localparam int SW = st_w(PAT_W);

    logic [SW-1:0]    state_q, state_d, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc;

    seq_fsm_pat_next #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .SW      (SW)
    ) u_next (
        .state      (state_q),
        .in_        (bus.in_),
        .overlap    (bus.overlap),
        .state_next (state_nxt)
    );

    always_comb begin
        inc     = bus.in_val && (state_nxt == SW'(PAT_W));
        state_d = bus.in_val ? state_nxt : state_q;
        cnt_d   = cnt_q;
        // A clear coinciding with a match keeps that match.
        if (bus.cnt_clr)
            cnt_d = inc ? CNT_W'(1) : '0;
        else if (inc && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.out       = (state_q == SW'(PAT_W));
    assign bus.match_cnt = cnt_q;

`ifdef SEQ_FSM_PAT_DET_STICKY_EN
    logic seen_q, seen_d;

    always_comb begin
        seen_d = bus.cnt_clr ? inc : (seen_q | inc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) seen_q <= 1'b0;
        else       seen_q <= seen_d;
    end

    assign bus.seen = seen_q;
`endif

endmodule

// File: tb/tb_seq_fsm_pat_det_mo.sv
// Scoreboard bench for seq_fsm_pat_det_mo: three parameterisations driven with
// directed streams, expected state/out/count queued per accepted edge.
module tb_seq_fsm_pat_det_mo;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seq_fsm_pat_det_mo_if #(.PAT_W(3), .CNT_W(8)) if0 ();
    seq_fsm_pat_det_mo_if #(.PAT_W(4), .CNT_W(8)) if1 ();
    seq_fsm_pat_det_mo_if #(.PAT_W(3), .CNT_W(2)) if2 ();

    seq_fsm_pat_det_mo #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(8))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    seq_fsm_pat_det_mo #(.PAT_W(4), .PATTERN(4'b1101), .CNT_W(8))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    seq_fsm_pat_det_mo #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2))
        dut2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        int    id;
        int    st;
        bit    o;
        int    cnt;
        string nm;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    function automatic int pw(input int id);
        return (id == 1) ? 4 : 3;
    endfunction

    task automatic get_act(input int id, output int st, output bit o, output int cnt);
        case (id)
            0:       begin st = int'(if0.state); o = if0.out; cnt = int'(if0.match_cnt); end
            1:       begin st = int'(if1.state); o = if1.out; cnt = int'(if1.match_cnt); end
            default: begin st = int'(if2.state); o = if2.out; cnt = int'(if2.match_cnt); end
        endcase
    endtask

    task automatic compare(input exp_t e);
        int st, cnt;
        bit o;
        get_act(e.id, st, o, cnt);
        checks++;
        if (st != e.st || o != e.o || cnt != e.cnt) begin
            failures++;
            $display("FAIL %s dut%0d: got state=%0d out=%0d cnt=%0d want state=%0d out=%0d cnt=%0d",
                     e.nm, e.id, st, o, cnt, e.st, e.o, e.cnt);
        end
    endtask

    // Monitor: outputs are registered, so they are stable at the falling edge.
    always @(negedge clk) begin
        while (sbq.size() > 0) compare(sbq.pop_front());
    end

    task automatic drive(input int id, input bit b, input bit v, input bit ovl, input bit clr);
        case (id)
            0:       begin if0.in_ = b; if0.in_val = v; if0.overlap = ovl; if0.cnt_clr = clr; end
            1:       begin if1.in_ = b; if1.in_val = v; if1.overlap = ovl; if1.cnt_clr = clr; end
            default: begin if2.in_ = b; if2.in_val = v; if2.overlap = ovl; if2.cnt_clr = clr; end
        endcase
    endtask

    task automatic step(input int id, input bit b, input bit v, input bit ovl, input bit clr,
                        input int est, input int ecnt, input string nm);
        exp_t e;
        drive(id, b, v, ovl, clr);
        @(posedge clk);
        e = '{id: id, st: est, o: (est == pw(id)), cnt: ecnt, nm: nm};
        sbq.push_back(e);
        @(negedge clk);
        drive(id, 1'b0, 1'b0, ovl, 1'b0);
    endtask

    // Async reset pulse inside the low clock phase, checked before any edge.
    task automatic pulse_reset(input string nm);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) compare('{id: i, st: 0, o: 1'b0, cnt: 0, nm: nm});
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, want finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) compare('{id: i, st: 0, o: 1'b0, cnt: 0, nm: "reset"});
        reset = 1'b0;
        @(negedge clk);

        // 101 overlapping, stream 1,0,1,0,1
        step(0, 1, 1, 1, 0, 1, 0, "ovl_b1");
        step(0, 0, 1, 1, 0, 2, 0, "ovl_b2");
        step(0, 1, 1, 1, 0, 3, 1, "ovl_b3");
        step(0, 0, 1, 1, 0, 2, 1, "ovl_b4");
        step(0, 1, 1, 1, 0, 3, 2, "ovl_b5");
        step(0, 0, 0, 1, 0, 3, 2, "ovl_hold");

        // Same stream, non-overlapping
        pulse_reset("rst_a");
        step(0, 1, 1, 0, 0, 1, 0, "novl_b1");
        step(0, 0, 1, 0, 0, 2, 0, "novl_b2");
        step(0, 1, 1, 0, 0, 3, 1, "novl_b3");
        step(0, 0, 1, 0, 0, 0, 1, "novl_b4");
        step(0, 1, 1, 0, 0, 1, 1, "novl_b5");

        // 1101 overlapping, stream 1,1,1,0,1,1,0,1
        step(1, 1, 1, 1, 0, 1, 0, "p4_b1");
        step(1, 1, 1, 1, 0, 2, 0, "p4_b2");
        step(1, 1, 1, 1, 0, 2, 0, "p4_b3");
        step(1, 0, 1, 1, 0, 3, 0, "p4_b4");
        step(1, 1, 1, 1, 0, 4, 1, "p4_b5");
        step(1, 1, 1, 1, 0, 2, 1, "p4_b6");
        step(1, 0, 1, 1, 0, 3, 1, "p4_b7");
        step(1, 1, 1, 1, 0, 4, 2, "p4_b8");

        // in_val gaps carry junk data that must be ignored
        pulse_reset("rst_b");
        step(0, 1, 1, 1, 0, 1, 0, "gap_b1");
        step(0, 0, 0, 1, 0, 1, 0, "gap_h1");
        step(0, 1, 0, 1, 0, 1, 0, "gap_h2");
        step(0, 1, 0, 1, 0, 1, 0, "gap_h3");
        step(0, 0, 1, 1, 0, 2, 0, "gap_b2");
        step(0, 1, 0, 1, 0, 2, 0, "gap_h4");
        step(0, 1, 1, 1, 0, 3, 1, "gap_b3");
        step(0, 0, 0, 1, 0, 3, 1, "gap_h5");

        // cnt_clr on the match edge keeps that match; alone it zeroes
        step(0, 0, 1, 1, 0, 2, 1, "clr_pre");
        step(0, 1, 1, 1, 1, 3, 1, "clr_match");
        step(0, 0, 0, 1, 1, 3, 0, "clr_only");

        // 2-bit counter saturates at 3 over five matches
        for (int i = 0; i < 11; i++) begin
            automatic int st_tab[11]  = '{1, 2, 3, 2, 3, 2, 3, 2, 3, 2, 3};
            automatic int cnt_tab[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3};
            step(2, (i % 2 == 0), 1, 1, 0, st_tab[i], cnt_tab[i], "sat");
        end

        // Reset mid-pattern in state 2 with a nonzero count
        pulse_reset("rst_c");
        step(0, 1, 1, 1, 0, 1, 0, "mid_b1");
        step(0, 0, 1, 1, 0, 2, 0, "mid_b2");
        step(0, 1, 1, 1, 0, 3, 1, "mid_b3");
        step(0, 0, 1, 1, 0, 2, 1, "mid_b4");
        pulse_reset("rst_mid");
        step(0, 1, 1, 1, 0, 1, 0, "post_rst");

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_fsm_pat_det_mo.md
Name: seq_fsm_pat_det_mo

Overview:
- Parametrised Moore-style serial pattern detector; next generation of the team's fixed 4-state, 1-input, 1-output sequence FSMs.
- Consumes one bit per qualified cycle and asserts `out` while the last PAT_W accepted bits equal PATTERN.
- Adds an input-valid qualifier, run-time overlap/non-overlap mode and a saturating match counter.
- Sits in front of the lab's sequential-control test blocks as the reusable detector primitive.

Parameters:
- PAT_W, 3, pattern length in bits; legal range 2..16.
- PATTERN, 3'b101, pattern value; bit PAT_W-1 is received first.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_  input  1  serial data bit.
- in_val  input  1  in_ is consumed only on cycles where in_val=1.
- overlap  input  1  1 = overlapping matches allowed; 0 = restart after a match.
- cnt_clr  input  1  synchronous clear of match_cnt.
- state  output  $clog2(PAT_W+1)  current state = number of pattern bits currently matched (0..PAT_W).
- out  output  1  Moore match flag; 1 iff state==PAT_W.
- match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Reset (async assert): state=0, out=0, match_cnt=0. Deassertion is sampled synchronously; first bit is consumed on the first edge with reset low.
- in_val=0: state and match_cnt hold; cnt_clr still acts.
- Match latency: out rises in the cycle after the edge that accepts the final pattern bit. It stays high until the next accepted bit; it holds across in_val=0 cycles.
- Next state from k<PAT_W:
  - if in_==PATTERN[PAT_W-1-k], next = k+1;
  - else next = length of the longest proper prefix of PATTERN that is a suffix of (first k pattern bits followed by in_). This is KMP failure semantics, computed at elaboration from PATTERN.
- Next state from PAT_W:
  - overlap=1: same rule as above, treating the matched string as the first PAT_W bits (KMP failure of the full pattern, then extended by in_).
  - overlap=0: next = 1 if in_==PATTERN[PAT_W-1], else 0.
- overlap is sampled only on edges that leave state PAT_W. Changing it mid-sequence has no other effect.
- Encoding values other than 0..PAT_W cannot occur; the default branch returns 0.
- With PAT_W=3, PATTERN=101, overlap=1 the transition table is exactly the 4-state A/B/C/D table (states 0..3).
- match_cnt increments on every edge where next state==PAT_W and in_val=1. It saturates at 2^CNT_W-1 with no wrap.
- cnt_clr with no increment: match_cnt=0.
- cnt_clr with a simultaneous increment: match_cnt=1, so the match is never lost.
- Reset asserted mid-pattern: immediate return to state 0, out=0, match_cnt=0.

Optional Feature:
- Macro SEQ_FSM_PAT_DET_STICKY_EN.
- Defined: adds output `seen` (1 bit). It sets on the first match and stays 1 until reset or cnt_clr; a simultaneous match and cnt_clr leaves seen=1.
- Undefined: port `seen` is absent; all other behaviour is unchanged.

Decomposition:
- Package seq_fsm_pkg holds:
  - the state-width helper (`$clog2(PAT_W+1)` wrapper);
  - a constant function computing the KMP next-state table from (PAT_W, PATTERN, in_);
  - the `OVL_ON`/`OVL_OFF` mode constants.
- One natural sub-module: seq_fsm_pat_next. It is purely combinational: (state, in_, overlap) -> state_next, with the table unrolled at elaboration.
- The top holds the state register, the Moore output, the counter and the optional sticky flag.

Test Plan:
- Defaults, overlap=1, in_val=1, stream 1,0,1,0,1:
  - state sequence 1,2,3,2,3;
  - out high in the cycles after bits 3 and 5;
  - match_cnt=2.
- Same stream with overlap=0:
  - state sequence 1,2,3,0,1;
  - out high once;
  - match_cnt=1.
- PAT_W=4, PATTERN=4'b1101, overlap=1, stream 1,1,1,0,1,1,0,1:
  - state sequence 1,2,2,3,4,2,3,4;
  - match_cnt=2.
- in_val gaps: stream 1,(gap x3),0,(gap),1 -> same result as contiguous 1,0,1; state and out hold during gaps; single match.
- CNT_W=2, 5 overlapping matches of 101 (stream 1,0,1,0,1,0,1,0,1,0,1) -> match_cnt saturates at 3.
- Counter and reset edge cases:
  - cnt_clr asserted on the match edge -> match_cnt=1.
  - Async reset pulse between edges while state=2 -> state=0, out=0, match_cnt=0 without waiting for a clk edge.
